pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage RISC-V pipeline. Each cycle it decides whether the PC and the IF/ID register advance, hold or flush, and whether a bubble enters ID/EX. Inputs are the decoded ID operands, the EX-stage load/branch status, the memory-busy indications and the IF/ID finish flag. After the finish flag it runs a drain/halt sequence, and it optionally keeps stall and flush statistics.

## Interface
- DRAIN_CYCLES, 4: cycles of bubble injection after `finish_in` before halting; legal range 1..15.
- CNT_W, 32: width of the performance counters.

- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_rs1, id_rs2  input  5 each  source register indices of the instruction in ID.
- id_use_rs1, id_use_rs2  input  1 each  the ID instruction actually reads rs1 / rs2.
- ex_rd  input  5  destination register of the instruction in EX.
- ex_mem_read  input  1  the EX instruction is a load.
- ex_branch_taken  input  1  a taken branch or jump was resolved in EX this cycle.
- imem_busy  input  1  instruction fetch not valid this cycle.
- dmem_busy  input  1  data memory access not complete this cycle.
- finish_in  input  1  IF/ID finish flag.
- pc_hold  output  1  PC keeps its value.
- if_id_hazard  output  1  IF/ID holds its contents.
- if_id_flush  output  1  IF/ID is loaded with zero.
- id_ex_flush  output  1  ID/EX is loaded with a bubble.
- pipe_freeze  output  1  ID/EX, EX/MEM and MEM/WB hold.
- halted  output  1  the controller is in HALT.
- stall_cnt  output  CNT_W  count of RUN-state cycles with `pc_hold`=1.
- flush_cnt  output  CNT_W  count of branch flushes.

## Operation
FSM states: RUN, DRAIN, HALT. Reset state is RUN; reset also sets the drain counter and both perf counters to 0.

Load-use hazard is defined as `ex_mem_read` && `ex_rd` != 0 && ((`id_use_rs1` && `id_rs1`==`ex_rd`) || (`id_use_rs2` && `id_rs2`==`ex_rd`)).

RUN: outputs are combinational. The first matching case below applies; outputs not listed are 0.
1. `dmem_busy`: `pc_hold`, `if_id_hazard`, `pipe_freeze` = 1. Branches and hazards are deferred; they stay valid because the stages hold.
2. `ex_branch_taken`: `if_id_flush` = 1 and `id_ex_flush` = 1; the PC takes the target.
3. Load-use hazard: `pc_hold`, `if_id_hazard`, `id_ex_flush` = 1 (exactly one bubble).
4. `imem_busy`: `pc_hold` = 1 and `if_id_flush` = 1.

RUN transitions:
- `finish_in` = 1 -> DRAIN, with the drain counter loaded to DRAIN_CYCLES-1.
- `finish_in` takes the state transition even if a branch flush occurs in the same cycle; that cycle's outputs still follow the priority list above.

DRAIN:
- `pc_hold` = 1 and `if_id_flush` = 1 every cycle. `ex_branch_taken`, load-use and `imem_busy` are ignored.
- When `dmem_busy` = 1, `pipe_freeze` = 1 and the counter holds.
- Otherwise the counter decrements. When it reads 0 and `dmem_busy` = 0, go to HALT.

HALT:
- `pc_hold`, `if_id_hazard`, `pipe_freeze`, `halted` = 1.
- Left only by reset.

Counters saturate at all-ones and never wrap.
- `stall_cnt` increments when state is RUN and `pc_hold` = 1.
- `flush_cnt` increments when state is RUN, `dmem_busy` = 0 and `ex_branch_taken` = 1.

## Timing
- All control outputs are combinational from the current state and inputs, with zero-cycle latency; they are consumed on the same clock edge.
- `halted` is a registered state decode.
- All outputs are 0 while `rst_n` = 0. Reset asserted mid-DRAIN returns the controller to RUN immediately.
- A load-use stall lasts exactly 1 cycle unless `dmem_busy` extends it; the second cycle sees a bubble in EX.
- Total latency from `finish_in` to `halted` = DRAIN_CYCLES cycles plus the number of cycles `dmem_busy` is high during DRAIN.

## Configuration
- PIPE_HAZARD_CTRL_PERF_EN defined: `stall_cnt` and `flush_cnt` are implemented as described in Operation.
- PIPE_HAZARD_CTRL_PERF_EN undefined: no counter flops are built; both outputs are tied to 0.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rd`=5, `id_rs1`=5, `id_use_rs1`=1 -> for one cycle `pc_hold`=`if_id_hazard`=`id_ex_flush`=1; `stall_cnt` goes 0->1.
- Same stimulus with `ex_rd`=0, or with `id_use_rs1`=0 -> all outputs 0.
- `ex_branch_taken`=1 together with the load-use condition -> `if_id_flush`=`id_ex_flush`=1, `pc_hold`=0; `flush_cnt`=1, `stall_cnt`=0.
- `dmem_busy` high for 3 cycles with `ex_branch_taken`=1 -> 3 cycles of `pipe_freeze`=1 with no flush, then the flush on cycle 4; `flush_cnt`=1.
- `finish_in` pulse with DRAIN_CYCLES=4 -> 4 cycles of `if_id_flush`=`pc_hold`=1, then `halted`=1 from cycle 5 onward. Repeat with `dmem_busy` high 2 cycles during DRAIN -> `halted` rises at cycle 7.
- Assert `rst_n`=0 during DRAIN -> all outputs 0 at once. After release: state RUN, `halted`=0, counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush controller for the 5-stage RISC-V pipeline. Decides each
// cycle whether PC and IF/ID advance, hold or flush, and whether a bubble enters
// ID/EX. After the IF/ID finish flag it drains the pipe and halts.
//
// Optional feature macro: PIPE_HAZARD_CTRL_PERF_EN
//   defined   -> saturating stall/flush statistics counters are built
//   undefined -> no counter flops; stall_cnt and flush_cnt tie to 0
//
// Parameters
//   DRAIN_CYCLES  bubble-injection cycles after finish_in before HALT (1..15)
//   CNT_W         width of the performance counters
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   id_rs1/id_rs2, id_use_rs1/2      ID-stage source operands and use flags
//   ex_rd, ex_mem_read               EX-stage destination and load flag
//   ex_branch_taken                  taken branch/jump resolved in EX
//   imem_busy, dmem_busy             memory not-ready indications
//   finish_in                        IF/ID finish flag
//   pc_hold, if_id_hazard,
//   if_id_flush, id_ex_flush,
//   pipe_freeze                      combinational pipeline controls
//   halted                           registered HALT-state decode
//   stall_cnt, flush_cnt             performance counters
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  input  logic             finish_in,
  output logic             pc_hold,
  output logic             if_id_hazard,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_freeze,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned DCNT_W = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [DCNT_W-1:0] r_drain_cnt;
  logic [DCNT_W-1:0] w_drain_cnt_nxt;
  logic              r_halted;

  logic w_load_use;
  logic w_pc_hold;
  logic w_if_id_hazard;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_pipe_freeze;

  // Load in EX whose destination is a live source of the ID instruction.
  assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

  // State and drain-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      r_halted    <= (w_state_nxt == ST_HALT);
    end
  end

  // Next-state logic; the drain counter holds while data memory is busy.
  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    case (r_state)
      ST_RUN: begin
        if (finish_in) begin
          w_state_nxt     = ST_DRAIN;
          w_drain_cnt_nxt = DCNT_W'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        if (!dmem_busy) begin
          if (r_drain_cnt == '0) begin
            w_state_nxt = ST_HALT;
          end else begin
            w_drain_cnt_nxt = r_drain_cnt - DCNT_W'(1);
          end
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt     = ST_RUN;
        w_drain_cnt_nxt = '0;
      end
    endcase
  end

  // Output decode; RUN applies the priority dmem > branch > load-use > imem.
  always_comb begin
    w_pc_hold      = 1'b0;
    w_if_id_hazard = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_pipe_freeze  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (dmem_busy) begin
          w_pc_hold      = 1'b1;
          w_if_id_hazard = 1'b1;
          w_pipe_freeze  = 1'b1;
        end else if (ex_branch_taken) begin
          w_if_id_flush  = 1'b1;
          w_id_ex_flush  = 1'b1;
        end else if (w_load_use) begin
          w_pc_hold      = 1'b1;
          w_if_id_hazard = 1'b1;
          w_id_ex_flush  = 1'b1;
        end else if (imem_busy) begin
          w_pc_hold      = 1'b1;
          w_if_id_flush  = 1'b1;
        end
      end
      ST_DRAIN: begin
        w_pc_hold     = 1'b1;
        w_if_id_flush = 1'b1;
        w_pipe_freeze = dmem_busy;
      end
      ST_HALT: begin
        w_pc_hold      = 1'b1;
        w_if_id_hazard = 1'b1;
        w_pipe_freeze  = 1'b1;
      end
      default: begin
        w_pc_hold = 1'b0;
      end
    endcase
  end

  // Controls are forced low while reset is asserted, independent of inputs.
  assign pc_hold      = rst_n & w_pc_hold;
  assign if_id_hazard = rst_n & w_if_id_hazard;
  assign if_id_flush  = rst_n & w_if_id_flush;
  assign id_ex_flush  = rst_n & w_id_ex_flush;
  assign pipe_freeze  = rst_n & w_pipe_freeze;
  assign halted       = r_halted;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall_inc;
  logic             w_flush_inc;

  assign w_stall_inc = (r_state == ST_RUN) && w_pc_hold;
  assign w_flush_inc = (r_state == ST_RUN) && !dmem_busy && ex_branch_taken;

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush_inc && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TB_DRAIN = 4;
  localparam int unsigned CNT_W    = 32;
  localparam int unsigned OBS_W    = 6 + 2 * CNT_W;
  localparam longint      CMAX     = (longint'(1) << CNT_W) - 1;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       use1;
    logic       use2;
    logic       memrd;
    logic       br;
    logic       ibusy;
    logic       dbusy;
    logic       fin;
  } stim_t;

  logic             clk;
  logic             rst_n;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
  logic             imem_busy, dmem_busy, finish_in;
  logic             pc_hold, if_id_hazard, if_id_flush, id_ex_flush;
  logic             pipe_freeze, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  // Model state: 0 = running, 1 = draining, 2 = halted.
  int     m_mode;
  int     m_left;
  longint m_stall;
  longint m_flush;

  logic [OBS_W-1:0] obs, exp;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(TB_DRAIN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy), .finish_in(finish_in),
    .pc_hold(pc_hold), .if_id_hazard(if_id_hazard), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .pipe_freeze(pipe_freeze), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OBS_W-1:0] get_obs();
    return {pc_hold, if_id_hazard, if_id_flush, id_ex_flush, pipe_freeze,
            halted, stall_cnt, flush_cnt};
  endfunction

  function automatic bit m_load_use();
    if (!ex_mem_read || ex_rd == 5'd0) return 1'b0;
    return (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
  endfunction

  // Expected controls as {pc_hold, hazard, if_flush, idex_flush, freeze, halted}.
  function automatic logic [5:0] m_ctrl();
    if (m_mode == 2) return 6'b110011;
    if (m_mode == 1) return {1'b1, 1'b0, 1'b1, 1'b0, dmem_busy, 1'b0};
    if (dmem_busy)       return 6'b110010;
    if (ex_branch_taken) return 6'b001100;
    if (m_load_use())    return 6'b110100;
    if (imem_busy)       return 6'b101000;
    return 6'b000000;
  endfunction

  function automatic logic [OBS_W-1:0] m_expect();
    logic [CNT_W-1:0] s, f;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    s = CNT_W'(m_stall);
    f = CNT_W'(m_flush);
`else
    s = '0;
    f = '0;
`endif
    return {m_ctrl(), s, f};
  endfunction

  // Model reaction to the upcoming rising edge with the current inputs.
  task automatic m_advance();
    logic [5:0] c;
    c = m_ctrl();
    if (m_mode == 0) begin
      if (c[5] && m_stall < CMAX) m_stall++;
      if (!dmem_busy && ex_branch_taken && m_flush < CMAX) m_flush++;
      if (finish_in) begin
        m_mode = 1;
        m_left = TB_DRAIN;
      end
    end else if (m_mode == 1) begin
      if (!dmem_busy) begin
        m_left--;
        if (m_left == 0) m_mode = 2;
      end
    end
  endtask

  task automatic m_reset();
    m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic apply(input stim_t s);
    @(negedge clk);
    id_rs1 = s.rs1; id_rs2 = s.rs2; ex_rd = s.rd;
    id_use_rs1 = s.use1; id_use_rs2 = s.use2; ex_mem_read = s.memrd;
    ex_branch_taken = s.br; imem_busy = s.ibusy; dmem_busy = s.dbusy;
    finish_in = s.fin;
    cyc++;
    #1;
  endtask

  function automatic stim_t rand_stim(input int fin_pct, input int dbusy_pct);
    stim_t s;
    s.rs1   = 5'($urandom_range(0, 3));
    s.rs2   = 5'($urandom_range(0, 3));
    s.rd    = 5'($urandom_range(0, 3));
    s.use1  = 1'($urandom_range(0, 1));
    s.use2  = 1'($urandom_range(0, 1));
    s.memrd = 1'($urandom_range(0, 1));
    s.br    = ($urandom_range(0, 99) < 25);
    s.ibusy = ($urandom_range(0, 99) < 25);
    s.dbusy = ($urandom_range(0, 99) < dbusy_pct);
    s.fin   = ($urandom_range(0, 99) < fin_pct);
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    stim_t s;
    for (int i = 0; i < 4; i++) begin
      s = rand_stim(50, 50);
      @(negedge clk);
      rst_n = 1'b0;
      apply(s);
      obs = get_obs();
      if (obs !== '0) $display("FAIL reset_outputs cyc=%0d got=%h exp=0", cyc, obs);
      else n_pass++;
      n_chk++;
    end
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    stim_t s;
    stim_t v[4];
    do_reset();
    s = '0; s.memrd = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.use1 = 1'b1;
    v[0] = s;                         // hazard: one-cycle stall
    v[1] = '0;                        // bubble now in EX
    v[2] = s; v[2].rd = 5'd0;         // x0 never hazards
    v[3] = s; v[3].use1 = 1'b0;       // rs1 not read
    for (int i = 0; i < 4; i++) begin
      apply(v[i]);
      exp = m_expect();
      obs = get_obs();
      if (obs !== exp) $display("FAIL load_use cyc=%0d got=%h exp=%h", cyc, obs, exp);
      else n_pass++;
      n_chk++;
      m_advance();
    end
    apply('0);
    exp = m_expect();
    obs = get_obs();
    if (obs !== exp) $display("FAIL load_use_cnt cyc=%0d got=%h exp=%h", cyc, obs, exp);
    else n_pass++;
    n_chk++;
  endtask

  task automatic test_branch_priority();
    stim_t s;
    do_reset();
    s = '0; s.memrd = 1'b1; s.rd = 5'd7; s.rs2 = 5'd7; s.use2 = 1'b1;
    s.br = 1'b1; s.ibusy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply(i == 0 ? s : stim_t'('0));
      exp = m_expect();
      obs = get_obs();
      if (obs !== exp) $display("FAIL branch_prio cyc=%0d got=%h exp=%h", cyc, obs, exp);
      else n_pass++;
      n_chk++;
      m_advance();
    end
  endtask

  task automatic test_dmem_defer();
    stim_t s;
    do_reset();
    s = '0; s.br = 1'b1; s.dbusy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s.dbusy = (i < 3);
      s.br    = (i < 4);
      apply(s);
      exp = m_expect();
      obs = get_obs();
      if (obs !== exp) $display("FAIL dmem_defer cyc=%0d got=%h exp=%h", cyc, obs, exp);
      else n_pass++;
      n_chk++;
      m_advance();
    end
  endtask

  task automatic test_drain();
    stim_t s;
    int    halt_at;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      halt_at = -1;
      for (int i = 0; i < 10; i++) begin
        s = '0;
        s.fin   = (i == 0);
        s.br    = (i == 0);
        s.dbusy = (pass == 1) && (i == 2 || i == 3);
        apply(s);
        if (halted === 1'b1 && halt_at < 0) halt_at = i;
        exp = m_expect();
        obs = get_obs();
        if (obs !== exp) $display("FAIL drain cyc=%0d got=%h exp=%h", cyc, obs, exp);
        else n_pass++;
        n_chk++;
        m_advance();
      end
      if (halt_at !== 5 + 2 * pass)
        $display("FAIL drain_latency pass=%0d got=%0d exp=%0d", pass, halt_at, 5 + 2 * pass);
      else n_pass++;
      n_chk++;
    end
  endtask

  task automatic test_reset_mid_drain();
    stim_t s;
    do_reset();
    s = '0; s.fin = 1'b1;
    apply(s);
    m_advance();
    s = '0; s.ibusy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply(s);
      m_advance();
    end
    #2;
    rst_n = 1'b0;
    #1;
    obs = get_obs();
    if (obs !== '0) $display("FAIL reset_mid_drain cyc=%0d got=%h exp=0", cyc, obs);
    else n_pass++;
    n_chk++;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply('0);
      exp = m_expect();
      obs = get_obs();
      if (obs !== exp) $display("FAIL after_reset cyc=%0d got=%h exp=%h", cyc, obs, exp);
      else n_pass++;
      n_chk++;
      m_advance();
    end
  endtask

  task automatic test_random_run();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      apply(rand_stim(0, 20));
      exp = m_expect();
      obs = get_obs();
      if (obs !== exp) $display("FAIL random_run cyc=%0d got=%h exp=%h", cyc, obs, exp);
      else n_pass++;
      n_chk++;
      m_advance();
    end
  endtask

  task automatic test_random_drain();
    stim_t s;
    for (int k = 0; k < 6; k++) begin
      do_reset();
      for (int i = 0; i < 40; i++) begin
        s = rand_stim((i < 10) ? 0 : 15, 35);
        apply(s);
        exp = m_expect();
        obs = get_obs();
        if (obs !== exp) $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc, obs, exp);
        else n_pass++;
        n_chk++;
        m_advance();
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; imem_busy = 1'b0; dmem_busy = 1'b0;
    finish_in = 1'b0;
    m_reset();
    test_reset();
    test_load_use();
    test_branch_priority();
    test_dmem_defer();
    test_drain();
    test_reset_mid_drain();
    test_random_run();
    test_random_drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
